// File: rtl/ybus_arbiter.sv
// Round-robin arbiter sharing one 4-phase Y channel among NREQ write buffers.
// Latches the winner's data/parity at grant and flags parity mismatches.
module ybus_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int CNTW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PARITYSEL,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] data_i,
  input  logic [NREQ-1:0]    parity_i,
  output logic [NREQ-1:0]    ack_o,
  output logic               YREQ,
  output logic [DW-1:0]      YDATA,
  output logic               YPARITY,
  input  logic               YACK,
  output logic [NREQ-1:0]    grant_o,
  output logic               busy_o,
  output logic               perr_o,
  output logic [CNTW-1:0]    perr_count_o
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_RELEASE} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_gidx;

  logic [DW-1:0]   w_data [NREQ];
  logic            w_found;
  logic [IW-1:0]   w_gidx;
  logic [IW:0]     w_j;
  logic            w_perr;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_data[gi] = data_i[gi*DW +: DW];
    end
  endgenerate

  // Scan downward so the candidate closest to r_last+1 is written last and wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_j     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_j = {1'b0, r_last} + (IW+1)'(i) + (IW+1)'(1);
      if (w_j >= (IW+1)'(NREQ)) begin
        w_j = w_j - (IW+1)'(NREQ);
      end
      if (req_i[w_j[IW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_j[IW-1:0];
      end
    end
  end

  assign w_perr = parity_i[w_gidx] != ((^w_data[w_gidx]) ^ PARITYSEL);
  assign busy_o = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last       <= IW'(NREQ - 1);
      r_gidx       <= '0;
      ack_o        <= '0;
      YREQ         <= 1'b0;
      YDATA        <= '0;
      YPARITY      <= 1'b0;
      grant_o      <= '0;
      perr_o       <= 1'b0;
      perr_count_o <= '0;
    end else begin
      perr_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A stale YACK from the previous consumer cycle blocks new grants.
          if (w_found && !YACK) begin
            r_state <= ST_FWD;
            r_gidx  <= w_gidx;
            r_last  <= w_gidx;
            grant_o <= NREQ'(1) << w_gidx;
            YDATA   <= w_data[w_gidx];
            YPARITY <= parity_i[w_gidx];
            YREQ    <= 1'b1;
            if (w_perr) begin
              perr_o <= 1'b1;
              if (perr_count_o != '1) begin
                perr_count_o <= perr_count_o + CNTW'(1);
              end
            end
          end
        end
        ST_FWD: begin
          if (YACK) begin
            YREQ          <= 1'b0;
            ack_o[r_gidx] <= 1'b1;
            r_state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!YACK && !req_i[r_gidx]) begin
            ack_o   <= '0;
            grant_o <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ybus_arbiter.md
Name: ybus_arbiter

Overview:
- Shares one downstream Y channel (YREQ/YACK 4-phase handshake, 32-bit YDATA plus YPARITY) between NREQ write-buffer instances.
- Round-robin grant. Per-request parity check against PARITYSEL. Registered Y outputs.
- Sits between the write buffers' Y-side outputs and the single Y-bus consumer.

Parameters:
- NREQ, 4, number of requesting write buffers (2..8).
- DW, 32, Y data width.
- CNTW, 8, width of the saturating parity-error counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-low reset.
- PARITYSEL  in  1  parity mode: 0 = even, 1 = odd. Sampled only at grant.
- req_i  in  NREQ  per-requester request (4-phase).
- data_i  in  NREQ*DW  requester k data in bits [k*DW +: DW].
- parity_i  in  NREQ  per-requester parity bit.
- ack_o  out  NREQ  per-requester acknowledge.
- YREQ  out  1  downstream request.
- YDATA  out  DW  downstream data.
- YPARITY  out  1  downstream parity.
- YACK  in  1  downstream acknowledge.
- grant_o  out  NREQ  one-hot owner of the channel. Zero when idle.
- busy_o  out  1  high in any state other than IDLE.
- perr_o  out  1  one-cycle pulse on parity mismatch.
- perr_count_o  out  CNTW  saturating parity-error count.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0. State is IDLE.
  - last_grant = NREQ-1, so requester 0 wins first.
  - perr_count_o = 0. Reset mid-transaction aborts it; there is no completion and no ack.
- FSM states: IDLE, FWD, RELEASE.
- IDLE, when any req_i bit is 1:
  - Pick the first set bit searching from last_grant+1 upward, wrapping modulo NREQ.
  - Register grant_o, YDATA = data_i[g] and YPARITY = parity_i[g]. Set YREQ = 1 on that same edge and go to FWD.
  - Latency: req_i high before edge N gives YREQ high after edge N.
  - last_grant <= g.
- Parity check at the grant edge:
  - Expected parity = (^data_i[g]) ^ PARITYSEL.
  - On mismatch: perr_o = 1 for exactly one cycle and perr_count_o increments, holding at 2^CNTW-1.
  - The data is still forwarded, with the received parity passed through unchanged.
- FWD:
  - YREQ, YDATA and YPARITY are held stable.
  - When YACK is sampled 1: YREQ <= 0, ack_o[g] <= 1, go to RELEASE.
- RELEASE:
  - Wait until YACK == 0 and req_i[g] == 0 are both sampled on the same edge. Conditions may be met in either order.
  - Then ack_o <= 0, grant_o <= 0, go to IDLE.
  - Minimum transaction: 3 cycles from grant to IDLE.
- Back-to-back:
  - A new grant may occur in the first IDLE cycle after RELEASE.
  - Requests arriving while busy are held by the requester, not queued.
- Fairness: with all requesters asserting, grants rotate 0,1,..,NREQ-1,0. Each requester waits at most NREQ-1 transactions.
- Requester protocol violations are ignored without corruption:
  - req_i[g] dropping before ack: the latched data is still completed downstream.
  - data_i changing after grant: the latched data is still completed downstream.
- YACK high in IDLE is ignored. No grant is issued until YACK is low.
- PARITYSEL change mid-transaction does not affect the current check.
- Only one ack_o bit is ever high. grant_o is always one-hot or zero.

Test Plan:
- Single request: req_i=0001, data_i[0]=0x0000_0003, parity_i[0]=0, PARITYSEL=0.
  - YREQ=1 with YDATA=0x3 one cycle later. perr_o stays 0.
  - After YACK=1: ack_o=0001. After req and YACK both drop: idle, grant_o=0.
- Round-robin: req_i=1111 held, with a consumer acking after 2 cycles → grant order 0,1,2,3,0. No gaps beyond 1 IDLE cycle.
- Parity error: data_i[2]=0x0000_0001, parity_i[2]=0, PARITYSEL=0.
  - perr_o pulses once and perr_count_o=1. YDATA=0x1 and YPARITY=0 are still forwarded.
  - Repeat 300 times with CNTW=8 → perr_count_o=255.
- Release ordering: req_i[1] drops 3 cycles before YACK drops, and vice versa.
  - ack_o[1] stays high until both are low, then clears the next edge.
- Reset mid-FWD: assert rst low while YREQ=1.
  - All outputs go 0 immediately. After release, the first grant goes to requester 0 when req_i=1111.
- Stale YACK: YACK=1 while idle with req_i=0100.
  - No grant until YACK=0, then requester 2 is granted.
